// File: rtl/main_mem_pkg.sv
// Shared types for the main-memory responder: request/response field types,
// the queued request record, FSM states and the latency LFSR helper.
package main_mem_pkg;

  localparam int BLOCK_ADDR_W = 16;
  localparam int BLOCK_DATA_W = 32;

  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_type_t;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} req_type_t;

  typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_W-1:0] block_data_t;

  typedef struct packed {
    cache_type_t          cache_type;
    req_type_t            req_type;
    main_mem_block_addr_t block_addr;
    block_data_t          block_data;
  } main_mem_req_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} main_mem_state_t;

  localparam logic [15:0] MAIN_MEM_LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/main_mem_if.sv
// Request/response bus between mem_ctrl (master) and main memory (slave).
interface main_mem_if;
  import main_mem_pkg::*;

  logic                 mem_req_valid;
  cache_type_t          mem_req_cache_type;
  req_type_t            mem_req_type;
  main_mem_block_addr_t mem_req_block_addr;
  block_data_t          mem_req_block_data;

  logic                 mem_resp_valid;
  cache_type_t          mem_resp_cache_type;
  block_data_t          mem_resp_block_data;
  logic                 overflow_err;

  modport master (
    output mem_req_valid, mem_req_cache_type, mem_req_type,
           mem_req_block_addr, mem_req_block_data,
    input  mem_resp_valid, mem_resp_cache_type, mem_resp_block_data,
           overflow_err
  );

  modport slave (
    input  mem_req_valid, mem_req_cache_type, mem_req_type,
           mem_req_block_addr, mem_req_block_data,
    output mem_resp_valid, mem_resp_cache_type, mem_resp_block_data,
           overflow_err
  );
endinterface

// File: rtl/main_mem_req_fifo.sv
// In-order pending-request queue; pointers carry an extra wrap bit so full
// and empty are distinguished without a separate count.
module main_mem_req_fifo
  import main_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  main_mem_req_t i_data,
  input  logic          i_pop,
  output main_mem_req_t o_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);

  main_mem_req_t r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/main_mem.sv
// Behavioural main memory: queues block requests and answers each one after
// a programmable latency. MAIN_MEM_RANDOM_LATENCY_EN adds 0..3 LFSR cycles.
module main_mem
  import main_mem_pkg::*;
#(
  parameter int MEM_LATENCY      = 4,
  parameter int REQ_Q_DEPTH      = 4,
  parameter int MEM_DEPTH_BLOCKS = 1024
) (
  input logic       clk,
  input logic       rst,
  main_mem_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH_BLOCKS);
  localparam int CNT_W = $clog2(MEM_LATENCY + 3) + 1;

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAT_M1 = cnt_t'(MEM_LATENCY - 1);

  main_mem_state_t r_state, w_state_nxt;
  cnt_t            r_cnt, w_cnt_nxt, w_load_cnt;
  main_mem_req_t   r_cur, w_cur_nxt, w_head, w_push_req;
  logic            w_full, w_empty, w_pop, w_fire_nxt, w_drop;
  logic [IDX_W-1:0] w_idx;

  logic        r_resp_valid;
  cache_type_t r_resp_tag;
  block_data_t r_resp_data;
  logic        r_ovf;

  block_data_t r_mem [MEM_DEPTH_BLOCKS] = '{default: '0};

  assign w_push_req = '{cache_type: bus.mem_req_cache_type,
                        req_type:   bus.mem_req_type,
                        block_addr: bus.mem_req_block_addr,
                        block_data: bus.mem_req_block_data};

  main_mem_req_fifo #(.DEPTH(REQ_Q_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.mem_req_valid),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_drop = bus.mem_req_valid && w_full && !w_pop;

`ifdef MAIN_MEM_RANDOM_LATENCY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst)        r_lfsr <= MAIN_MEM_LFSR_SEED;
    else if (w_pop) r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_load_cnt = LAT_M1 + cnt_t'(r_lfsr[1:0]);
`else
  assign w_load_cnt = LAT_M1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cur_nxt   = w_head;
          w_cnt_nxt   = w_load_cnt;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - cnt_t'(1);
        end else if (!w_empty) begin
          w_pop     = 1'b1;
          w_cur_nxt = w_head;
          w_cnt_nxt = w_load_cnt;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Registered response: load it on the edge that enters the cnt==0 cycle.
    w_fire_nxt = (w_state_nxt == BUSY) && (w_cnt_nxt == '0);
  end

  assign w_idx = w_cur_nxt.block_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cur   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cur   <= w_cur_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_tag   <= ICACHE;
      r_resp_data  <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_resp_valid <= w_fire_nxt;
      if (!w_fire_nxt) begin
        r_resp_tag  <= ICACHE;
        r_resp_data <= '0;
      end else begin
        r_resp_tag <= w_cur_nxt.cache_type;
        if (w_cur_nxt.req_type == WRITE) r_resp_data <= w_cur_nxt.block_data;
        else                             r_resp_data <= r_mem[w_idx];
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Array is deliberately outside reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && w_fire_nxt && (w_cur_nxt.req_type == WRITE))
      r_mem[w_idx] <= w_cur_nxt.block_data;
  end

  assign bus.mem_resp_valid      = r_resp_valid;
  assign bus.mem_resp_cache_type = r_resp_tag;
  assign bus.mem_resp_block_data = r_resp_data;
  assign bus.overflow_err        = r_ovf;
endmodule

// File: tb/tb_main_mem.sv
// Self-checking bench for main_mem: per-cycle event-time reference model,
// vector table, directed multi-cycle sequences and random traffic.
module tb_main_mem;
  import main_mem_pkg::*;

  localparam int L     = 4;
  localparam int DEPTH = 4;
  localparam int NBLK  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_mem_if bus();

  main_mem #(.MEM_LATENCY(L), .REQ_Q_DEPTH(DEPTH), .MEM_DEPTH_BLOCKS(NBLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: request accepted at edge a is popped at p = max(a+1, p_prev+L)
  // and its response is visible after edge p+L-1.
  typedef struct { int fire; req_type_t rt; cache_type_t ct; int idx; logic [31:0] data; } pend_t;
  typedef struct { int a; int p; } hist_t;
  typedef struct { req_type_t rt; cache_type_t ct; logic [15:0] addr; logic [31:0] data; logic [31:0] exp; } vec_t;

  pend_t       pend[$];
  hist_t       hist[$];
  logic [31:0] mm [NBLK];
  int          last_p = -1000;
  bit          ovf_exp = 1'b0;
  int          resp_seen = 0;
  int          last_resp_cyc = -1;
  logic [31:0] last_resp_data = '0;
  cache_type_t last_resp_tag = ICACHE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit          ev;
    cache_type_t et;
    logic [31:0] ed;
    pend_t       e;
    ev = 1'b0; et = ICACHE; ed = '0;
`ifndef MAIN_MEM_RANDOM_LATENCY_EN
    if (pend.size() > 0 && pend[0].fire == cyc) begin
      e = pend.pop_front();
      if (e.rt == WRITE) mm[e.idx] = e.data;
      ev = 1'b1; et = e.ct; ed = mm[e.idx];
    end
    chk("resp_valid", 32'(bus.mem_resp_valid), 32'(ev));
    chk("resp_tag", 32'(bus.mem_resp_cache_type), 32'(et));
    chk("resp_data", bus.mem_resp_block_data, ed);
    chk("overflow_err", 32'(bus.overflow_err), 32'(ovf_exp));
`endif
    if (bus.mem_resp_valid) begin
      resp_seen++;
      last_resp_cyc  = cyc;
      last_resp_data = bus.mem_resp_block_data;
      last_resp_tag  = bus.mem_resp_cache_type;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic model_push(input req_type_t rt, input cache_type_t ct,
                            input logic [15:0] addr, input logic [31:0] data);
    int a, p, occ;
    bit pop_here;
    a = cyc + 1; occ = 0; pop_here = 1'b0;
    foreach (hist[i]) begin
      if (hist[i].a < a && hist[i].p >= a) occ++;
      if (hist[i].p == a) pop_here = 1'b1;
    end
    if (occ < DEPTH || pop_here) begin
      p = (a + 1 > last_p + L) ? a + 1 : last_p + L;
      last_p = p;
      hist.push_back('{a: a, p: p});
      pend.push_back('{fire: p + L - 1, rt: rt, ct: ct, idx: int'(addr) % NBLK, data: data});
    end else begin
      ovf_exp = 1'b1;
    end
  endtask

  task automatic model_reset();
    pend.delete();
    hist.delete();
    last_p  = -1000;
    ovf_exp = 1'b0;
  endtask

  task automatic send(input req_type_t rt, input cache_type_t ct,
                      input logic [15:0] addr, input logic [31:0] data);
    bus.mem_req_valid      = 1'b1;
    bus.mem_req_type       = rt;
    bus.mem_req_cache_type = ct;
    bus.mem_req_block_addr = addr;
    bus.mem_req_block_data = data;
    model_push(rt, ct, addr, data);
    step();
    bus.mem_req_valid = 1'b0;
  endtask

  vec_t tbl [10];

  initial begin
    int n0, a, lat;
    logic [31:0] exp_d;
    req_type_t rt;
    cache_type_t ct;
    logic [15:0] ad;
    logic [31:0] dd;

    tbl[0] = '{WRITE, DCACHE, 16'd5,      32'h0000A5A5, 32'h0000A5A5};
    tbl[1] = '{READ,  ICACHE, 16'd5,      32'h0,        32'h0000A5A5};
    tbl[2] = '{READ,  ICACHE, 16'd9,      32'hFFFF0000, 32'h0};
    tbl[3] = '{WRITE, ICACHE, 16'd1029,   32'h12345678, 32'h12345678};
    tbl[4] = '{READ,  DCACHE, 16'd5,      32'h0,        32'h12345678};
    tbl[5] = '{WRITE, DCACHE, 16'd1023,   32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[6] = '{READ,  ICACHE, 16'd1023,   32'h0,        32'hFFFFFFFF};
    tbl[7] = '{READ,  DCACHE, 16'd0,      32'h0,        32'h0};
    tbl[8] = '{READ,  ICACHE, 16'hFFFF,   32'h0,        32'hFFFFFFFF};
    tbl[9] = '{WRITE, DCACHE, 16'd0,      32'hCAFEF00D, 32'hCAFEF00D};

    for (int i = 0; i < NBLK; i++) mm[i] = '0;
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_type       = READ;
    bus.mem_req_cache_type = ICACHE;
    bus.mem_req_block_addr = '0;
    bus.mem_req_block_data = '0;

    rst = 1'b1;
    idle(3);
    chk("reset_valid", 32'(bus.mem_resp_valid), 32'd0);
    chk("reset_tag", 32'(bus.mem_resp_cache_type), 32'(ICACHE));
    chk("reset_data", bus.mem_resp_block_data, 32'd0);
    chk("reset_ovf", 32'(bus.overflow_err), 32'd0);
    rst = 1'b0;
    idle(2);

`ifdef MAIN_MEM_RANDOM_LATENCY_EN
    for (int i = 0; i < 20; i++) begin
      rt = req_type_t'($urandom_range(0, 1));
      ct = cache_type_t'($urandom_range(0, 1));
      ad = 16'($urandom_range(0, 7));
      dd = $urandom();
      if (rt == WRITE) mm[ad] = dd;
      exp_d = mm[ad];
      n0 = resp_seen; a = cyc + 1;
      send(rt, ct, ad, dd);
      for (int k = 0; k < L + 8; k++) if (resp_seen == n0) step();
      lat = last_resp_cyc - a;
      chk("rl_count", 32'(resp_seen - n0), 32'd1);
      chk("rl_latency_in_range", 32'(lat >= L && lat <= L + 3), 32'd1);
      chk("rl_tag", 32'(last_resp_tag), 32'(ct));
      chk("rl_data", last_resp_data, exp_d);
      step();
    end
`else
    // Isolated vectors: exact latency, tag and data.
    for (int i = 0; i < 10; i++) begin
      n0 = resp_seen; a = cyc + 1;
      send(tbl[i].rt, tbl[i].ct, tbl[i].addr, tbl[i].data);
      idle(L + 3);
      chk("tbl_count", 32'(resp_seen - n0), 32'd1);
      chk("tbl_latency", 32'(last_resp_cyc - a), 32'(L));
      chk("tbl_tag", 32'(last_resp_tag), 32'(tbl[i].ct));
      chk("tbl_data", last_resp_data, tbl[i].exp);
    end

    // Write then read of the same block on consecutive cycles.
    n0 = resp_seen; a = cyc + 1;
    send(WRITE, ICACHE, 16'd3, 32'h1);
    send(READ, DCACHE, 16'd3, 32'h0);
    idle(3 * L);
    chk("raw_count", 32'(resp_seen - n0), 32'd2);
    chk("raw_second_cycle", 32'(last_resp_cyc - a), 32'(2 * L));
    chk("raw_second_data", last_resp_data, 32'h1);

    // Back-to-back stream until the queue overflows.
    n0 = resp_seen;
    for (int i = 0; i < 7; i++) begin
      send(WRITE, DCACHE, 16'(20 + i), 32'h100 + 32'(i));
      if (i == 5) chk("ovf_clear_on_push_pop", 32'(bus.overflow_err), 32'd0);
      if (i == 6) chk("ovf_set_on_drop", 32'(bus.overflow_err), 32'd1);
    end
    idle(7 * L);
    chk("ovf_sticky", 32'(bus.overflow_err), 32'd1);
    chk("ovf_resp_count", 32'(resp_seen - n0), 32'd6);
    send(READ, ICACHE, 16'd26, 32'h0);
    idle(L + 2);
    chk("dropped_write_absent", last_resp_data, 32'h0);
    send(READ, ICACHE, 16'd25, 32'h0);
    idle(L + 2);
    chk("last_accepted_write", last_resp_data, 32'h105);

    // Reset while busy with two requests queued behind the one in service.
    n0 = resp_seen;
    send(WRITE, DCACHE, 16'd40, 32'hDEAD0040);
    send(WRITE, DCACHE, 16'd41, 32'hDEAD0041);
    send(WRITE, DCACHE, 16'd42, 32'hDEAD0042);
    rst = 1'b1;
    model_reset();
    step();
    chk("rst_mid_valid", 32'(bus.mem_resp_valid), 32'd0);
    chk("rst_mid_tag", 32'(bus.mem_resp_cache_type), 32'(ICACHE));
    chk("rst_mid_data", bus.mem_resp_block_data, 32'd0);
    chk("rst_mid_ovf", 32'(bus.overflow_err), 32'd0);
    rst = 1'b0;
    idle(4 * L);
    chk("rst_no_resp", 32'(resp_seen - n0), 32'd0);
    send(READ, DCACHE, 16'd40, 32'h0);
    idle(L + 2);
    chk("rst_write_discarded", last_resp_data, 32'h0);
    chk("array_survives_reset", 32'(mm[5]), 32'h12345678);
    send(READ, ICACHE, 16'd5, 32'h0);
    idle(L + 2);
    chk("array_kept_after_rst", last_resp_data, 32'h12345678);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 40) begin
        rt = req_type_t'($urandom_range(0, 1));
        ct = cache_type_t'($urandom_range(0, 1));
        ad = 16'($urandom_range(0, 15) + NBLK * $urandom_range(0, 63));
        dd = $urandom();
        send(rt, ct, ad, dd);
      end else begin
        step();
      end
    end
    idle(8 * L);
    chk("random_drained", 32'(pend.size()), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
